// File: rtl/jk_excite_driver.sv
// Excitation driver for an external bank of JK flip-flops: accepts a target word,
// drives J/K for one cycle, waits SETTLE cycles, then checks Q and reports the outcome.
module jk_excite_driver #(
    parameter int WIDTH         = 4,
    parameter int SETTLE        = 1,
    parameter int PREFER_TOGGLE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    // J for each bit: set bits that must rise; with toggling preferred, falling bits too.
    function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] t);
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
        rise = ~q & t;
        fall = q & ~t;
        if (PREFER_TOGGLE != 0) begin
            return rise | fall;
        end else begin
            return rise;
        end
    endfunction

    function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] t);
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
        rise = ~q & t;
        fall = q & ~t;
        if (PREFER_TOGGLE != 0) begin
            return rise | fall;
        end else begin
            return fall;
        end
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] mism_s;

    assign mism_s = q_in ^ tgt_q;

    // Next-state and next-output logic; J/K and status outputs default to idle values.
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        j_d       = '0;
        k_d       = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        mask_d    = '0;
        err_cnt_d = err_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (tgt_valid && ready_q) begin
                    tgt_d   = tgt_data;
                    j_d     = excite_j(q_in, tgt_data);
                    k_d     = excite_k(q_in, tgt_data);
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                cnt_d   = SETTLE_LAST;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    done_d  = 1'b1;
                    err_d   = |mism_s;
                    mask_d  = mism_s;
                    state_d = ST_IDLE;
                    if ((|mism_s) && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Ready is registered, so it is low for the cycle following any reset edge.
        ready_d = (state_d == ST_IDLE);
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tgt_q     <= '0;
            cnt_q     <= 4'd0;
            j_q       <= '0;
            k_q       <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            mask_q    <= '0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            j_q       <= j_d;
            k_q       <= k_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            mask_q    <= mask_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign tgt_ready = ready_q;
    assign j         = j_q;
    assign k         = k_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_mask  = mask_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: doc/jk_excite_driver.md
Name: jk_excite_driver

Overview:
- Drives an external bank of WIDTH JK flip-flops (jk_ff instances) toward a requested target state.
- Accepts a target word over a valid/ready handshake and computes per-bit J/K excitation from the current Q.
- Applies the excitation for one clock, waits for settling, then checks Q against the target and reports done, error and a mismatch mask.
- Acts as the stimulus/control side of the JK register interface: it produces j/k and consumes q.

Parameters:
WIDTH, 4, number of JK flip-flops driven (1..32)
SETTLE, 1, cycles after the drive cycle before Q is compared (1..15)
PREFER_TOGGLE, 0, 0 = changing bits use set/reset only; 1 = changing bits use J=K=1 (toggle)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
tgt_valid  input  1  target word valid
tgt_data  input  WIDTH  requested next Q
tgt_ready  output  1  block idle and able to accept a target
q_in  input  WIDTH  current Q of the JK bank
j  output  WIDTH  J inputs to the JK bank (registered)
k  output  WIDTH  K inputs to the JK bank (registered)
done  output  1  one-cycle pulse when a transaction completes
err  output  1  valid with done: 1 = Q differs from target
err_mask  output  WIDTH  valid with done: bits where Q differs from target
err_cnt  output  8  saturating count of failed transactions

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is synchronous and active-high. While rst=1 at a rising edge:
  - state goes to IDLE
  - j=k=0, done=0, err=0, err_mask=0, err_cnt=0
  - tgt_ready=0 in the cycle after any reset edge, then 1 from the first non-reset edge onward.
- Reset mid-transaction aborts it: no done pulse, and j=k=0 from the next cycle.
- States: IDLE, DRIVE, WAIT.
- IDLE:
  - tgt_ready=1, j=k=0.
  - On tgt_valid & tgt_ready at edge E0: capture tgt_data into tgt_q, go to DRIVE.
- DRIVE (exactly 1 cycle, after E0):
  - j/k carry the excitation computed at E0 from q_in and tgt_data.
  - Bank samples j/k at edge E1.
  - Go to WAIT with counter = SETTLE-1.
- WAIT (SETTLE cycles):
  - j=k=0, so the bank holds.
  - At the last WAIT edge (E0+1+SETTLE): register done=1, err=|(q_in^tgt_q), err_mask=q_in^tgt_q.
  - If err is set, increment err_cnt unless it is 255 (saturates; never wraps).
  - Return to IDLE.
- Outputs: done/err/err_mask are high for exactly one cycle. err/err_mask return to 0 with done.
- Excitation per bit (q = q_in, t = target):
  - q=0,t=0: J=0, K=0
  - q=0,t=1: J=1, K=PREFER_TOGGLE
  - q=1,t=0: J=PREFER_TOGGLE, K=1
  - q=1,t=1: J=0, K=0
- Latency: done is asserted in the cycle following edge E0+1+SETTLE. tgt_ready rises in that same cycle.
- Throughput: one transaction per SETTLE+2 cycles. Back-to-back acceptance is allowed at the edge ending the done cycle.
- tgt_valid while tgt_ready=0 is ignored. It does not queue.
- tgt_data need not be held after acceptance.
- q_in is sampled only at E0 (excitation) and at the final WAIT edge (check). Changes at other times are ignored.
- Target equal to current Q is a legal transaction: j=k=0 throughout, done with err=0.

Test Plan:
Bench setup for all cases: WIDTH=4, SETTLE=1, four jk_ff instances sharing clk/rst, q_in = their Q; PREFER_TOGGLE=0 unless noted.
1. Reset: rst=1 for 3 edges with tgt_valid=1, tgt_data=1111 -> j=k=0000, done=0, err_cnt=0, tgt_ready=0; after release tgt_ready=1 and the first accept happens only then.
2. Set: Q=0000, target 1010 -> DRIVE cycle j=1010, k=0000; done at E0+2 edges, err=0, err_mask=0000, Q=1010.
3. Mixed: Q=1010, target 0110 -> j=0100, k=1000, done, Q=0110. Repeat with PREFER_TOGGLE=1 -> j=k=1100, Q=0110.
4. Hold and busy: target 0110 while Q=0110 -> j=k=0000, done, err=0. tgt_valid held high 6 cycles with changing data -> exactly 2 accepts (cycles 0 and 3), each followed by one done.
5. Fault: bench forces q_in[0]=0, target 0001 -> err=1, err_mask=0001, err_cnt=1. Repeat 300 times -> err_cnt=255, stays 255.
6. Reset during DRIVE (Q=0000, target 1111) -> next cycle j=k=0000, no done pulse, err_cnt=0, tgt_ready=1 after release.
